regfile_wb_arbiter: RTL and testbench

- Shares the register file's single write port between two writeback requesters: ALU result (alu_*) and load/memory result (mem_*).
- Keeps a 32-entry pending-write scoreboard. Issue reserves rd; the busy bit clears when the write actually commits.
- Gives decode rs/rt busy flags for stall generation.
- Sits between the execute/memory stages and the register file write inputs (rd, writedata, regwrite).

---
 rtl/regfile_wb_arbiter_if.sv | 57 +++++
 rtl/regfile_wb_arbiter.sv | 117 +++++++++++
 tb/tb_regfile_wb_arbiter.sv | 214 +++++++++++++++++++++
 3 files changed

// File: rtl/regfile_wb_arbiter_if.sv
// Writeback/scoreboard bus between the execute/memory stages, the issue and
// decode stages, and the register file write port.
// The slave modport is the arbiter; the master modport is its surroundings.
interface regfile_wb_arbiter_if #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5
);
    // ALU writeback requester
    logic              alu_valid;
    logic              alu_ready;
    logic [ADDR_W-1:0] alu_rd;
    logic [DATA_W-1:0] alu_data;
    // load/memory writeback requester
    logic              mem_valid;
    logic              mem_ready;
    logic [ADDR_W-1:0] mem_rd;
    logic [DATA_W-1:0] mem_data;
    // issue-stage destination reservation
    logic              rsv_valid;
    logic              rsv_ready;
    logic [ADDR_W-1:0] rsv_rd;
    // pipeline flush of the scoreboard
    logic              flush;
    // decode-stage source lookups
    logic [ADDR_W-1:0] rs;
    logic [ADDR_W-1:0] rt;
    logic              rs_busy;
    logic              rt_busy;
    // register file write port
    logic [ADDR_W-1:0] rf_rd;
    logic [DATA_W-1:0] rf_writedata;
    logic              rf_regwrite;

    modport slave (
        input  alu_valid, alu_rd, alu_data,
        output alu_ready,
        input  mem_valid, mem_rd, mem_data,
        output mem_ready,
        input  rsv_valid, rsv_rd,
        output rsv_ready,
        input  flush, rs, rt,
        output rs_busy, rt_busy,
        output rf_rd, rf_writedata, rf_regwrite
    );

    modport master (
        output alu_valid, alu_rd, alu_data,
        input  alu_ready,
        output mem_valid, mem_rd, mem_data,
        input  mem_ready,
        output rsv_valid, rsv_rd,
        input  rsv_ready,
        output flush, rs, rt,
        input  rs_busy, rt_busy,
        input  rf_rd, rf_writedata, rf_regwrite
    );
endinterface

// File: rtl/regfile_wb_arbiter.sv
// Arbitrates ALU and memory writebacks onto one register file write port and
// tracks pending writes in a per-register busy scoreboard for decode stalls.
// Latency 1 cycle from accepted request to rf_regwrite; ready is combinational.
// Ports: clk, rst_n (async active-low), bus (slave modport: alu_*/mem_*
// requests, rsv_* reservations, flush, rs/rt lookups, rf_* write outputs).
// Backpressure: loser of arbitration or blocked reservation sees ready=0 and
// must hold its request; a granted writeback sustains one write per cycle.
module regfile_wb_arbiter #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5
) (
    input  logic                   clk,
    input  logic                   rst_n,
    regfile_wb_arbiter_if.slave    bus
);
    localparam int NREG = 2 ** ADDR_W;

    typedef enum logic {
        GRANT_ALU = 1'b0,
        GRANT_MEM = 1'b1
    } grant_e;

    grant_e            last_grant;
    logic [NREG-1:0]   busy;
    logic [NREG-1:0]   busy_nxt;

    logic              alu_gnt;
    logic              mem_gnt;
    logic              xfer;
    logic [ADDR_W-1:0] win_rd;
    logic [DATA_W-1:0] win_data;
    logic              rsv_xfer;

    // Arbitration. Both requesting the same nonzero register means the load
    // and the ALU op target one destination; the load goes first so the ALU
    // value, issued later in program order, is what lands last.
    always_comb begin
        alu_gnt = 1'b0;
        mem_gnt = 1'b0;
        if (bus.alu_valid && bus.mem_valid) begin
            if ((bus.alu_rd == bus.mem_rd) && (bus.alu_rd != '0)) begin
                mem_gnt = 1'b1;
            end else if (last_grant == GRANT_MEM) begin
                alu_gnt = 1'b1;
            end else begin
                mem_gnt = 1'b1;
            end
        end else if (bus.alu_valid) begin
            alu_gnt = 1'b1;
        end else if (bus.mem_valid) begin
            mem_gnt = 1'b1;
        end
    end

    assign bus.alu_ready = alu_gnt;
    assign bus.mem_ready = mem_gnt;
    assign xfer          = alu_gnt || mem_gnt;
    assign win_rd        = mem_gnt ? bus.mem_rd   : bus.alu_rd;
    assign win_data      = mem_gnt ? bus.mem_data : bus.alu_data;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_grant <= GRANT_MEM;
        end else if (xfer) begin
            last_grant <= mem_gnt ? GRANT_MEM : GRANT_ALU;
        end
    end

    // Registered write port. rd=0 writes are accepted but never assert
    // regwrite; address/data hold when nothing is written.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bus.rf_regwrite  <= 1'b0;
            bus.rf_rd        <= '0;
            bus.rf_writedata <= '0;
        end else begin
            bus.rf_regwrite <= xfer && (win_rd != '0);
            if (xfer && (win_rd != '0)) begin
                bus.rf_rd        <= win_rd;
                bus.rf_writedata <= win_data;
            end
        end
    end

    // Reservations look only at the registered bitmap, so a register whose
    // write commits this cycle is still blocked until the next one.
    assign bus.rsv_ready = !busy[bus.rsv_rd] || (bus.rsv_rd == '0);
    assign rsv_xfer      = bus.rsv_valid && bus.rsv_ready;

    assign bus.rs_busy = busy[bus.rs];
    assign bus.rt_busy = busy[bus.rt];

    // Clear on commit (when the register file samples the write), then set on
    // reservation, so a fresh reservation of a register whose unreserved write
    // is committing is not lost. Flush overrides both.
    always_comb begin
        busy_nxt = busy;
        if (bus.rf_regwrite) begin
            busy_nxt[bus.rf_rd] = 1'b0;
        end
        if (rsv_xfer && (bus.rsv_rd != '0)) begin
            busy_nxt[bus.rsv_rd] = 1'b1;
        end
        if (bus.flush) begin
            busy_nxt = '0;
        end
        busy_nxt[0] = 1'b0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy <= '0;
        end else begin
            busy <= busy_nxt;
        end
    end
endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Directed bench for regfile_wb_arbiter: arbitration order, write latency,
// scoreboard reserve/commit/flush behaviour and asynchronous reset.
module tb_regfile_wb_arbiter;
    localparam int DATA_W = 32;
    localparam int ADDR_W = 5;

    logic clk;
    logic rst_n;
    int   errors;
    int   checks;

    regfile_wb_arbiter_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) bus ();

    regfile_wb_arbiter #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Advance to just after the next rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [4:0]  rr_rd   [4];
        logic [31:0] rr_data [4];
        logic        rr_alu  [4];

        errors = 0;
        checks = 0;
        rst_n  = 1'b0;
        bus.alu_valid = 1'b0; bus.alu_rd = '0; bus.alu_data = '0;
        bus.mem_valid = 1'b0; bus.mem_rd = '0; bus.mem_data = '0;
        bus.rsv_valid = 1'b0; bus.rsv_rd = '0;
        bus.flush = 1'b0;
        bus.rs = 5'd5;
        bus.rt = 5'd7;

        // Reset state and idle outputs
        #12;
        chk("rst_regwrite", bus.rf_regwrite, 1'b0);
        chk("rst_rf_rd", bus.rf_rd, 5'd0);
        chk("rst_rf_data", bus.rf_writedata, 32'h0);
        chk("rst_rs_busy", bus.rs_busy, 1'b0);
        chk("rst_rt_busy", bus.rt_busy, 1'b0);
        chk("idle_alu_ready", bus.alu_ready, 1'b0);
        chk("idle_mem_ready", bus.mem_ready, 1'b0);
        rst_n = 1'b1;

        // Single ALU write, latency 1
        bus.alu_valid = 1'b1; bus.alu_rd = 5'd3; bus.alu_data = 32'hDEADBEEF;
        #1;
        chk("alu1_ready", bus.alu_ready, 1'b1);
        chk("alu1_mem_ready", bus.mem_ready, 1'b0);
        tick();
        bus.alu_valid = 1'b0;
        chk("alu1_regwrite", bus.rf_regwrite, 1'b1);
        chk("alu1_rf_rd", bus.rf_rd, 5'd3);
        chk("alu1_rf_data", bus.rf_writedata, 32'hDEADBEEF);
        tick();
        chk("idle_regwrite", bus.rf_regwrite, 1'b0);
        chk("idle_rf_rd_hold", bus.rf_rd, 5'd3);

        // Memory-only write leaves last_grant=MEM so ALU wins the next tie
        bus.mem_valid = 1'b1; bus.mem_rd = 5'd1; bus.mem_data = 32'h11;
        #1;
        chk("mem1_ready", bus.mem_ready, 1'b1);
        tick();
        bus.mem_valid = 1'b0;
        chk("mem1_rf_rd", bus.rf_rd, 5'd1);
        chk("mem1_rf_data", bus.rf_writedata, 32'h11);

        // Round robin with both requesters always valid
        rr_alu  = '{1'b1, 1'b0, 1'b1, 1'b0};
        rr_rd   = '{5'd4, 5'd6, 5'd4, 5'd6};
        rr_data = '{32'hA4, 32'hB6, 32'hA4, 32'hB6};
        bus.alu_valid = 1'b1; bus.alu_rd = 5'd4; bus.alu_data = 32'hA4;
        bus.mem_valid = 1'b1; bus.mem_rd = 5'd6; bus.mem_data = 32'hB6;
        for (int i = 0; i < 4; i++) begin
            #1;
            chk($sformatf("rr%0d_alu_ready", i), bus.alu_ready, rr_alu[i]);
            chk($sformatf("rr%0d_mem_ready", i), bus.mem_ready, !rr_alu[i]);
            tick();
            chk($sformatf("rr%0d_regwrite", i), bus.rf_regwrite, 1'b1);
            chk($sformatf("rr%0d_rf_rd", i), bus.rf_rd, rr_rd[i]);
            chk($sformatf("rr%0d_rf_data", i), bus.rf_writedata, rr_data[i]);
        end
        bus.alu_valid = 1'b0;
        bus.mem_valid = 1'b0;

        // Same destination: memory first, ALU value lands last
        bus.alu_valid = 1'b1; bus.alu_rd = 5'd9; bus.alu_data = 32'hA9;
        bus.mem_valid = 1'b1; bus.mem_rd = 5'd9; bus.mem_data = 32'h99;
        #1;
        chk("same_mem_ready", bus.mem_ready, 1'b1);
        chk("same_alu_held", bus.alu_ready, 1'b0);
        tick();
        bus.mem_valid = 1'b0;
        chk("same_first_data", bus.rf_writedata, 32'h99);
        chk("same_first_rd", bus.rf_rd, 5'd9);
        #1;
        chk("same_alu_ready2", bus.alu_ready, 1'b1);
        tick();
        bus.alu_valid = 1'b0;
        chk("same_second_regwrite", bus.rf_regwrite, 1'b1);
        chk("same_second_data", bus.rf_writedata, 32'hA9);

        // Scoreboard reserve / block / commit / re-reserve of r12
        bus.rs = 5'd12;
        bus.rsv_valid = 1'b1; bus.rsv_rd = 5'd12;
        #1;
        chk("rsv12_ready", bus.rsv_ready, 1'b1);
        chk("rsv12_not_yet_busy", bus.rs_busy, 1'b0);
        tick();
        chk("rsv12_busy", bus.rs_busy, 1'b1);
        chk("rsv12_again_blocked", bus.rsv_ready, 1'b0);
        bus.rsv_valid = 1'b0;
        bus.alu_valid = 1'b1; bus.alu_rd = 5'd12; bus.alu_data = 32'hC0C0;
        tick();
        bus.alu_valid = 1'b0;
        bus.rsv_valid = 1'b1;
        #1;
        chk("commit12_regwrite", bus.rf_regwrite, 1'b1);
        chk("commit12_still_busy", bus.rs_busy, 1'b1);
        chk("commit12_rsv_blocked", bus.rsv_ready, 1'b0);
        bus.rsv_valid = 1'b0;
        tick();
        chk("after12_clear", bus.rs_busy, 1'b0);
        bus.rsv_valid = 1'b1;
        #1;
        chk("rersv12_ready", bus.rsv_ready, 1'b1);
        tick();
        bus.rsv_valid = 1'b0;
        chk("rersv12_busy", bus.rs_busy, 1'b1);

        // Register 0: reservation accepted but never tracked, write suppressed
        bus.rs = 5'd0;
        bus.rsv_valid = 1'b1; bus.rsv_rd = 5'd0;
        #1;
        chk("rsv0_ready", bus.rsv_ready, 1'b1);
        tick();
        bus.rsv_valid = 1'b0;
        chk("rsv0_rs_busy", bus.rs_busy, 1'b0);
        bus.alu_valid = 1'b1; bus.alu_rd = 5'd0; bus.alu_data = 32'h55;
        #1;
        chk("wb0_ready", bus.alu_ready, 1'b1);
        tick();
        bus.alu_valid = 1'b0;
        chk("wb0_regwrite", bus.rf_regwrite, 1'b0);
        chk("wb0_rf_rd_hold", bus.rf_rd, 5'd12);

        // Reserve 2, 3, 4
        for (int r = 2; r <= 4; r++) begin
            bus.rsv_valid = 1'b1; bus.rsv_rd = 5'(r);
            tick();
        end
        bus.rsv_valid = 1'b0;
        bus.rs = 5'd2; bus.rt = 5'd3;
        #1;
        chk("rsv2_busy", bus.rs_busy, 1'b1);
        chk("rsv3_busy", bus.rt_busy, 1'b1);
        bus.rt = 5'd4;
        #1;
        chk("rsv4_busy", bus.rt_busy, 1'b1);

        // Flush with a same-cycle ALU write to 2 and a dropped reservation of 5
        bus.flush = 1'b1;
        bus.alu_valid = 1'b1; bus.alu_rd = 5'd2; bus.alu_data = 32'h22;
        bus.rsv_valid = 1'b1; bus.rsv_rd = 5'd5;
        #1;
        chk("flush_alu_ready", bus.alu_ready, 1'b1);
        tick();
        bus.flush = 1'b0;
        bus.alu_valid = 1'b0;
        bus.rsv_valid = 1'b0;
        chk("flush_r2_clear", bus.rs_busy, 1'b0);
        chk("flush_r4_clear", bus.rt_busy, 1'b0);
        bus.rt = 5'd5;
        bus.rs = 5'd12;
        #1;
        chk("flush_r5_dropped", bus.rt_busy, 1'b0);
        chk("flush_r12_clear", bus.rs_busy, 1'b0);
        chk("flush_regwrite", bus.rf_regwrite, 1'b1);
        chk("flush_rf_rd", bus.rf_rd, 5'd2);
        chk("flush_rf_data", bus.rf_writedata, 32'h22);

        // Asynchronous reset while a write is on the port
        rst_n = 1'b0;
        #1;
        chk("arst_regwrite", bus.rf_regwrite, 1'b0);
        chk("arst_rf_rd", bus.rf_rd, 5'd0);
        chk("arst_rf_data", bus.rf_writedata, 32'h0);
        #3;
        rst_n = 1'b1;
        tick();
        chk("post_rst_regwrite", bus.rf_regwrite, 1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
